pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// pipeline_controller: operand forwarding, load-use/branch/memory hazard
// handling and a small drain/memory-wait sequencer for a 5-stage pipeline.
module pipeline_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        PCSrcD,
    input  logic        BranchTakenE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    input  logic        StatClr,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemTimeout,
    output logic [15:0] StallCount,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DRAIN   = 2'b01,
        MEMWAIT = 2'b10
    } ctrlState_t;

    ctrlState_t  state_q, state_d;
    ctrlState_t  retState_q, retState_d;
    logic [1:0]  drainCnt_q, drainCnt_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [15:0] stallCnt_q, stallCnt_d;
    logic        timeout_q, timeout_d;

    logic memStall;
    logic ldStall;
    logic branchFlush;
    logic drainActive;
    logic drainStart;

    // A memory stall freezes everything up to M and bubbles W.
    assign memStall    = MemReqM & ~MemReadyM;
    // Load-use hazard; the drain sequence already holds fetch, so it is ignored there.
    assign ldStall     = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E))
                         & (state_q != DRAIN) & ~memStall;
    assign branchFlush = BranchTakenE & ~memStall;
    // Drain outputs stay active on the MEMWAIT exit cycle when we are resuming a drain.
    assign drainActive = ~memStall & ((state_q == DRAIN) |
                         ((state_q == MEMWAIT) & (retState_q == DRAIN)));
    assign drainStart  = (state_q == RUN) & PCSrcD & ~memStall & ~ldStall & ~BranchTakenE;

    assign MemTimeout = timeout_q;
    assign StallCount = stallCnt_q;
    assign State      = state_q;

    // Forwarding select: the M-stage result is newer than W, so it wins.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            if (RegWriteM && (RA1E == WA3M)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RA1E == WA3W)) begin
                ForwardAE = 2'b01;
            end
            if (RegWriteM && (RA2E == WA3M)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RA2E == WA3W)) begin
                ForwardBE = 2'b01;
            end
        end
    end

    // Stall/flush outputs: OR of all active hazards, flushes masked only by memory stall.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldStall | drainActive | drainStart;
            StallD = ldStall;
            FlushD = branchFlush | drainActive;
            FlushE = branchFlush | ldStall;
        end
    end

    // Sequencer next state plus the statistics counters.
    always_comb begin
        state_d    = state_q;
        retState_d = retState_q;
        drainCnt_d = drainCnt_q;
        waitCnt_d  = waitCnt_q;
        case (state_q)
            RUN: begin
                if (memStall) begin
                    state_d    = MEMWAIT;
                    retState_d = RUN;
                end else if (drainStart) begin
                    state_d    = DRAIN;
                    drainCnt_d = 2'd3;
                end
            end
            DRAIN: begin
                if (memStall) begin
                    state_d    = MEMWAIT;
                    retState_d = DRAIN;
                end else if (BranchTakenE || (drainCnt_q <= 2'd1)) begin
                    state_d    = RUN;
                    drainCnt_d = 2'd0;
                end else begin
                    drainCnt_d = drainCnt_q - 2'd1;
                end
            end
            MEMWAIT: begin
                if (memStall) begin
                    if (waitCnt_q != 8'hFF) begin
                        waitCnt_d = waitCnt_q + 8'd1;
                    end
                end else begin
                    waitCnt_d = 8'd0;
                    if ((retState_q == DRAIN) && !BranchTakenE) begin
                        state_d = DRAIN;
                    end else begin
                        state_d    = RUN;
                        drainCnt_d = 2'd0;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                retState_d = RUN;
                drainCnt_d = 2'd0;
                waitCnt_d  = 8'd0;
            end
        endcase

        timeout_d = StatClr ? 1'b0 : (timeout_q | (waitCnt_d == 8'hFF));

        if (StatClr) begin
            stallCnt_d = 16'd0;
        end else if (StallF && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end else begin
            stallCnt_d = stallCnt_q;
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            retState_q <= RUN;
            drainCnt_q <= 2'd0;
            waitCnt_q  <= 8'd0;
            stallCnt_q <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            retState_q <= retState_d;
            drainCnt_q <= drainCnt_d;
            waitCnt_q  <= waitCnt_d;
            stallCnt_q <= stallCnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule
